// File: rtl/dmem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Valid/ready RV32I data-memory controller with sub-word access,
//            misalignment detection and configurable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         c_idxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_cntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [31:0] r_rspRdata;
  logic        r_rspErr;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [2:0]        w_funct3;
  logic [c_idxW-1:0] w_idx;
  logic              w_f3Legal;
  logic              w_misalign;
  logic              w_err;
  logic              w_access;
  logic [31:0]       w_word;
  logic [31:0]       w_shift;
  logic [31:0]       w_loadData;
  logic [31:0]       w_wlane;
  logic [3:0]        w_be;
  logic              w_unusedBits;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

  assign w_accept = req_valid && (r_state == IDLE);

  // In IDLE the live request is used so a zero-latency access completes on its acceptance edge.
  assign w_we     = (r_state == IDLE) ? req_we     : r_we;
  assign w_addr   = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;
  assign w_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_idx    = w_addr[c_idxW+1:2];

  assign w_f3Legal  = w_we ? (w_funct3 inside {3'b000, 3'b001, 3'b010})
                           : (w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_misalign = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                      ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_err      = !w_f3Legal || w_misalign;

  // Errored requests never reach WAIT, so w_err only matters on the IDLE path.
  assign w_access = rst && ((w_accept && (LATENCY == 0) && !w_err) ||
                            ((r_state == WAIT) && (r_cnt == 4'd0)));

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_addr[1:0], 3'b000};

  always_comb begin
    w_loadData = 32'd0;
    case (w_funct3)
      3'b000:  w_loadData = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_loadData = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_loadData = w_word;
      3'b100:  w_loadData = {24'd0, w_shift[7:0]};
      3'b101:  w_loadData = {16'd0, w_shift[15:0]};
      default: w_loadData = 32'd0;
    endcase
  end

  always_comb begin
    w_wlane = w_wdata;
    w_be    = 4'b0000;
    case (w_funct3[1:0])
      2'b00: begin
        w_wlane = {4{w_wdata[7:0]}};
        w_be    = 4'b0001 << w_addr[1:0];
      end
      2'b01: begin
        w_wlane = {2{w_wdata[15:0]}};
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_wlane = w_wdata;
        w_be    = 4'b1111;
      end
      default: begin
        w_wlane = w_wdata;
        w_be    = 4'b0000;
      end
    endcase
  end

  assign w_unusedBits = ^{w_addr[31:c_idxW+2], w_shift[31:16]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
      r_rspRdata <= 32'd0;
      r_rspErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            if ((LATENCY == 0) || w_err) begin
              r_state    <= RESP;
              r_rspErr   <= w_err;
              r_rspRdata <= (w_err || req_we) ? 32'd0 : w_loadData;
            end else begin
              r_cnt   <= c_cntInit;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state    <= RESP;
            r_rspErr   <= 1'b0;
            r_rspRdata <= r_we ? 32'd0 : w_loadData;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_rspErr   <= 1'b0;
          r_rspRdata <= 32'd0;
        end
        default: begin
          r_state    <= IDLE;
          r_rspErr   <= 1'b0;
          r_rspRdata <= 32'd0;
        end
      endcase
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_access && w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire
